rf_write_arbiter: RTL

Shares the single write port of the 8×8-bit register file between two writeback requesters: port A (ALU result) and port B (memory load data). Each requester has a one-entry holding register with a valid/ready handshake. The block grants the oldest held entry, drives the register file's IN / INADDRESS / WRITE from registered outputs, and exports a per-register pending-write scoreboard for hazard checks.

---
 rtl/rf_write_arbiter_if.sv | 27 ++
 rtl/rf_write_arbiter.sv | 65 ++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: request handshakes, register-file write port and pending scoreboard of the writeback arbiter.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG = 8
);
  logic A_VALID;
  logic A_READY;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_DATA;
  logic B_VALID;
  logic B_READY;
  logic [ADDR_W-1:0] B_ADDR;
  logic [DATA_W-1:0] B_DATA;
  logic [DATA_W-1:0] RF_IN;
  logic [ADDR_W-1:0] RF_INADDRESS;
  logic RF_WRITE;
  logic [NREG-1:0] PENDING;
  modport master (
    output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
    input A_READY, B_READY, RF_IN, RF_INADDRESS, RF_WRITE, PENDING
  );
  modport slave (
    input A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
    output A_READY, B_READY, RF_IN, RF_INADDRESS, RF_WRITE, PENDING
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: oldest-first sharing of the register file write port between ALU (A) and load (B) writeback.
module rf_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG = 8
) (
  input logic CLK,
  input logic RESET,
  rf_write_arbiter_if.slave bus
);
  logic ha_full, hb_full, older_b;
  logic [ADDR_W-1:0] ha_addr, hb_addr, rf_addr;
  logic [DATA_W-1:0] ha_data, hb_data, rf_in;
  logic rf_write;
  logic grant_a, grant_b, acc_a, acc_b;
  logic [NREG-1:0] pend;
  assign grant_a = ha_full && (!hb_full || !older_b);
  assign grant_b = hb_full && (!ha_full || older_b);
  assign bus.A_READY = !RESET && (!ha_full || grant_a);
  assign bus.B_READY = !RESET && (!hb_full || grant_b);
  assign acc_a = bus.A_VALID && bus.A_READY;
  assign acc_b = bus.B_VALID && bus.B_READY;
  assign bus.RF_IN = rf_in;
  assign bus.RF_INADDRESS = rf_addr;
  assign bus.RF_WRITE = rf_write;
  assign bus.PENDING = pend;
  always_comb begin
    pend = '0;
    for (int i = 0; i < NREG; i++)
      pend[i] = (ha_full && ha_addr == ADDR_W'(i)) || (hb_full && hb_addr == ADDR_W'(i)) ||
                (rf_write && rf_addr == ADDR_W'(i));
  end
  // A lone capture is younger than whatever stays held; a double capture makes A the older one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ha_full <= 1'b0;
      hb_full <= 1'b0;
      older_b <= 1'b0;
      ha_addr <= '0;
      hb_addr <= '0;
      ha_data <= '0;
      hb_data <= '0;
      rf_write <= 1'b0;
      rf_in <= '0;
      rf_addr <= '0;
    end else begin
      if (acc_a) begin
        ha_addr <= bus.A_ADDR;
        ha_data <= bus.A_DATA;
      end
      if (acc_b) begin
        hb_addr <= bus.B_ADDR;
        hb_data <= bus.B_DATA;
      end
      ha_full <= acc_a || (ha_full && !grant_a);
      hb_full <= acc_b || (hb_full && !grant_b);
      older_b <= (acc_a && !acc_b) ? 1'b1 : acc_b ? 1'b0 : older_b;
      rf_write <= grant_a || grant_b;
      if (grant_a || grant_b) begin
        rf_in <= grant_b ? hb_data : ha_data;
        rf_addr <= grant_b ? hb_addr : ha_addr;
      end
    end
  end
endmodule
